// File: rtl/scale_ctrl.sv
// Scale-mode controller and frame-buffer read-address sequencer for the display path.
// Latency: 2 cycles to addr_out, 2+BRAM_LATENCY to pixel_valid_out; no back-pressure, one pixel/cycle.
module scale_ctrl #(
   parameter int FB_WIDTH     = 240,
   parameter int FB_HEIGHT    = 320,
   parameter int BRAM_LATENCY = 2
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        btn_in,
   input  logic        new_frame_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   output logic [1:0]  scale_out,
   output logic        change_pending_out,
   output logic [16:0] addr_out,
   output logic        addr_valid_out,
   output logic        pixel_valid_out,
   output logic [10:0] hcount_out,
   output logic [9:0]  vcount_out
);

   localparam int          DEPTH = 2 + BRAM_LATENCY;
   localparam logic [10:0] FB_W  = 11'(FB_WIDTH);
   localparam logic [9:0]  FB_H  = 10'(FB_HEIGHT);

   logic [1:0]  staged;
   logic [1:0]  staged_nxt;
   logic        btn_q;
   logic        btn_rise;
   logic [1:0]  shift_h;
   logic        shift_v;
   logic [10:0] sh_c;
   logic [9:0]  sv_c;
   logic        valid_c;
   logic [10:0] sh_q;
   logic [9:0]  sv_q;
   logic        valid0_q;
   logic [16:0] addr_c;

   logic [DEPTH-1:0] pv_pipe;
   logic [10:0]      h_pipe [DEPTH];
   logic [9:0]       v_pipe [DEPTH];

   function automatic logic [1:0] next_scale(input logic [1:0] s);
      case (s)
         2'b00:   next_scale = 2'b11;
         2'b11:   next_scale = 2'b10;
         2'b10:   next_scale = 2'b00;
         default: next_scale = 2'b11;
      endcase
   endfunction

   // A press coincident with new_frame_in is folded into the scale taken at that boundary.
   always_comb begin
      btn_rise   = btn_in & ~btn_q;
      staged_nxt = btn_rise ? next_scale(staged) : staged;
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         btn_q              <= 1'b0;
         staged             <= 2'b00;
         scale_out          <= 2'b00;
         change_pending_out <= 1'b0;
      end else begin
         btn_q              <= btn_in;
         staged             <= staged_nxt;
         change_pending_out <= (staged != scale_out);
         if (new_frame_in) begin
            scale_out <= staged_nxt;
         end
      end
   end

   always_comb begin
      shift_h = 2'd0;
      shift_v = 1'b0;
      case (scale_out)
         2'b10: begin shift_h = 2'd2; shift_v = 1'b1; end
         2'b11: begin shift_h = 2'd1; shift_v = 1'b1; end
         default: ;
      endcase
      sh_c    = hcount_in >> shift_h;
      sv_c    = vcount_in >> shift_v;
      valid_c = (sh_c < FB_W) && (sv_c < FB_H);
   end

   generate
      if (FB_WIDTH == 240) begin : g_mul240
         // 240*sv as 256*sv - 16*sv keeps the multiply out of a DSP.
         always_comb begin
            addr_c = ({7'd0, sv_q} << 8) - ({7'd0, sv_q} << 4) + {6'd0, sh_q};
         end
      end else begin : g_mul_generic
         always_comb begin
            addr_c = 17'(17'(sv_q) * 17'(FB_WIDTH)) + {6'd0, sh_q};
         end
      end
   endgenerate

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         sh_q           <= '0;
         sv_q           <= '0;
         valid0_q       <= 1'b0;
         addr_out       <= '0;
         addr_valid_out <= 1'b0;
      end else begin
         sh_q           <= sh_c;
         sv_q           <= sv_c;
         valid0_q       <= valid_c;
         addr_out       <= valid0_q ? addr_c : '0;
         addr_valid_out <= valid0_q;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         pv_pipe <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            h_pipe[i] <= '0;
            v_pipe[i] <= '0;
         end
      end else begin
         pv_pipe[0] <= valid_c;
         h_pipe[0]  <= hcount_in;
         v_pipe[0]  <= vcount_in;
         for (int i = 1; i < DEPTH; i++) begin
            pv_pipe[i] <= pv_pipe[i-1];
            h_pipe[i]  <= h_pipe[i-1];
            v_pipe[i]  <= v_pipe[i-1];
         end
      end
   end

   assign pixel_valid_out = pv_pipe[DEPTH-1];
   assign hcount_out      = h_pipe[DEPTH-1];
   assign vcount_out      = v_pipe[DEPTH-1];

endmodule

// File: tb/tb_scale_ctrl.sv
// Bench for scale_ctrl: directed test-plan vectors plus random traffic against an arithmetic model.
module tb_scale_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        btn;
   logic        nf;
   logic [10:0] hc;
   logic [9:0]  vc;
   logic [1:0]  scale_o;
   logic        pend_o;
   logic [16:0] addr_o;
   logic        avld_o;
   logic        pvld_o;
   logic [10:0] hout;
   logic [9:0]  vout;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [10:0] h;
      logic [9:0]  v;
      logic        vld;
      logic [16:0] addr;
   } ent_t;

   ent_t hist[$];
   int   m_scale, m_staged, m_pend, m_prev;
   int   order_next[4] = '{3, 3, 0, 2};

   scale_ctrl dut (
      .clk_in             (clk),
      .rst_n_in           (rst_n),
      .btn_in             (btn),
      .new_frame_in       (nf),
      .hcount_in          (hc),
      .vcount_in          (vc),
      .scale_out          (scale_o),
      .change_pending_out (pend_o),
      .addr_out           (addr_o),
      .addr_valid_out     (avld_o),
      .pixel_valid_out    (pvld_o),
      .hcount_out         (hout),
      .vcount_out         (vout)
   );

   always #5 clk = ~clk;

   function automatic ent_t ref_map(input int h, input int v, input int scale);
      ent_t e;
      int hd, vd, sh, sv;
      case (scale)
         2:       begin hd = 4; vd = 2; end
         3:       begin hd = 2; vd = 2; end
         default: begin hd = 1; vd = 1; end
      endcase
      sh     = h / hd;
      sv     = v / vd;
      e.h    = 11'(h);
      e.v    = 10'(v);
      e.vld  = (sh < 240) && (sv < 320);
      e.addr = e.vld ? 17'(sh + 240 * sv) : 17'd0;
      return e;
   endfunction

   function automatic void model_reset();
      ent_t z;
      z.h = '0; z.v = '0; z.vld = 1'b0; z.addr = '0;
      hist.delete();
      for (int i = 0; i < 4; i++) hist.push_back(z);
      m_scale = 0; m_staged = 0; m_pend = 0; m_prev = 0;
   endfunction

   // hist[3] is the newest sample; addr reflects hist[2], aligned pixel reflects hist[0].
   task automatic tick();
      ent_t e;
      int   new_staged, new_pend;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
      end else begin
         e = ref_map(int'(hc), int'(vc), m_scale);
         hist.push_back(e);
         hist.delete(0);
         new_staged = (btn && m_prev == 0) ? order_next[m_staged] : m_staged;
         new_pend   = (m_staged != m_scale) ? 1 : 0;
         if (nf) m_scale = new_staged;
         m_staged = new_staged;
         m_pend   = new_pend;
         m_prev   = btn ? 1 : 0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      btn = 1'b0; nf = 1'b0; hc = '0; vc = '0;
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      if (scale_o !== 2'b00) begin errors++; $display("FAIL reset_scale: got %0d expected 0", scale_o); end
      checks++;
      if (pend_o !== 1'b0) begin errors++; $display("FAIL reset_pending: got %0b expected 0", pend_o); end
      checks++;
      if (addr_o !== 17'd0 || avld_o !== 1'b0) begin
         errors++; $display("FAIL reset_addr: got addr=%0d vld=%0b expected 0/0", addr_o, avld_o);
      end
      checks++;
      if (pvld_o !== 1'b0 || hout !== 11'd0 || vout !== 10'd0) begin
         errors++; $display("FAIL reset_align: got pv=%0b h=%0d v=%0d expected 0/0/0", pvld_o, hout, vout);
      end
      checks++;
   endtask

   task automatic test_scale00();
      hc = 11'd100; vc = 10'd50;
      tick();
      hc = 11'd2000; vc = 10'd0;
      tick();
      if (addr_o !== 17'd12100 || avld_o !== 1'b1) begin
         errors++; $display("FAIL s00_addr: got addr=%0d vld=%0b expected 12100/1", addr_o, avld_o);
      end
      checks++;
      tick();
      if (avld_o !== 1'b0 || addr_o !== 17'd0) begin
         errors++; $display("FAIL s00_blank: got addr=%0d vld=%0b expected 0/0", addr_o, avld_o);
      end
      checks++;
      tick();
      if (pvld_o !== 1'b1 || hout !== 11'd100 || vout !== 10'd50) begin
         errors++; $display("FAIL s00_align: got pv=%0b h=%0d v=%0d expected 1/100/50", pvld_o, hout, vout);
      end
      checks++;
   endtask

   task automatic test_buttons();
      do_reset();
      for (int i = 0; i < 2; i++) begin
         btn = 1'b1; tick();
         btn = 1'b0; tick();
      end
      tick();
      if (scale_o !== 2'b00 || pend_o !== 1'b1) begin
         errors++; $display("FAIL btn_staged: got scale=%0d pend=%0b expected 0/1", scale_o, pend_o);
      end
      checks++;
      hc = '0; vc = '0; nf = 1'b1; tick();
      nf = 1'b0; tick();
      if (scale_o !== 2'b10 || pend_o !== 1'b0) begin
         errors++; $display("FAIL btn_frame: got scale=%0d pend=%0b expected 2/0", scale_o, pend_o);
      end
      checks++;
      hc = 11'd959; vc = 10'd639; tick();
      hc = 11'd960; vc = 10'd639; tick();
      if (addr_o !== 17'd76799 || avld_o !== 1'b1) begin
         errors++; $display("FAIL s10_max: got addr=%0d vld=%0b expected 76799/1", addr_o, avld_o);
      end
      checks++;
      hc = '0; vc = '0; tick();
      if (addr_o !== 17'd0 || avld_o !== 1'b0) begin
         errors++; $display("FAIL s10_edge: got addr=%0d vld=%0b expected 0/0", addr_o, avld_o);
      end
      checks++;
      btn = 1'b1;
      repeat (100) tick();
      btn = 1'b0; tick();
      if (scale_o !== 2'b10 || pend_o !== 1'b1) begin
         errors++; $display("FAIL btn_hold_pend: got scale=%0d pend=%0b expected 2/1", scale_o, pend_o);
      end
      checks++;
      nf = 1'b1; tick();
      nf = 1'b0; tick();
      if (scale_o !== 2'b00 || pend_o !== 1'b0) begin
         errors++; $display("FAIL btn_hold_once: got scale=%0d pend=%0b expected 0/0", scale_o, pend_o);
      end
      checks++;
   endtask

   task automatic test_same_cycle();
      do_reset();
      hc = '0; vc = '0;
      btn = 1'b1; nf = 1'b1; tick();
      btn = 1'b0; nf = 1'b0;
      if (scale_o !== 2'b11 || pend_o !== 1'b0) begin
         errors++; $display("FAIL same_cycle_scale: got scale=%0d pend=%0b expected 3/0", scale_o, pend_o);
      end
      checks++;
      tick();
      if (pend_o !== 1'b0) begin errors++; $display("FAIL same_cycle_pend: got %0b expected 0", pend_o); end
      checks++;
      hc = 11'd300; vc = 10'd100; tick();
      hc = 11'd480; vc = 10'd0;   tick();
      if (addr_o !== 17'd12150 || avld_o !== 1'b1) begin
         errors++; $display("FAIL s11_addr: got addr=%0d vld=%0b expected 12150/1", addr_o, avld_o);
      end
      checks++;
      hc = '0; vc = '0; tick();
      if (addr_o !== 17'd0 || avld_o !== 1'b0) begin
         errors++; $display("FAIL s11_edge: got addr=%0d vld=%0b expected 0/0", addr_o, avld_o);
      end
      checks++;
   endtask

   task automatic test_async_reset();
      for (int i = 0; i < 6; i++) begin
         hc = 11'($urandom_range(0, 470)); vc = 10'($urandom_range(0, 630));
         tick();
      end
      #2 rst_n = 1'b0;
      #1;
      if (scale_o !== 2'b00 || pend_o !== 1'b0 || addr_o !== 17'd0 || avld_o !== 1'b0 ||
          pvld_o !== 1'b0 || hout !== 11'd0 || vout !== 10'd0) begin
         errors++;
         $display("FAIL async_reset: got scale=%0d pend=%0b addr=%0d av=%0b pv=%0b h=%0d v=%0d expected all 0",
                  scale_o, pend_o, addr_o, avld_o, pvld_o, hout, vout);
      end
      checks++;
      model_reset();
      tick();
      tick();
      rst_n = 1'b1;
      hc = 11'd100; vc = 10'd50; tick();
      hc = '0; vc = '0; tick();
      if (addr_o !== 17'd12100 || avld_o !== 1'b1 || scale_o !== 2'b00) begin
         errors++; $display("FAIL async_resume: got addr=%0d vld=%0b scale=%0d expected 12100/1/0",
                            addr_o, avld_o, scale_o);
      end
      checks++;
   endtask

   task automatic test_random();
      logic [44:0] got, exp;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) == 0) btn = ~btn;
         nf = (i % 50 == 49);
         if (nf) begin
            hc = '0; vc = '0;
         end else begin
            hc = 11'($urandom_range(0, 1100)); vc = 10'($urandom_range(0, 700));
         end
         tick();
         got = {scale_o, pend_o, addr_o, avld_o, pvld_o, hout, vout, 1'b0};
         exp = {2'(m_scale), 1'(m_pend), hist[2].addr, hist[2].vld, hist[0].vld, hist[0].h, hist[0].v, 1'b0};
         if (got !== exp) begin
            errors++;
            $display("FAIL random_cycle %0d: got %h expected %h", i, got, exp);
         end
         checks++;
      end
      btn = 1'b0; nf = 1'b0;
   endtask

   initial begin
      test_reset();
      test_scale00();
      test_buttons();
      test_same_cycle();
      test_async_reset();
      do_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/scale_ctrl.md
# scale_ctrl

Scale-mode controller and read-address sequencer for the 240x320 camera frame buffer on the display path. It accepts scale-change requests from a user button and holds each request until the next frame boundary so a frame never mixes scales. It maps display hcount/vcount to a scaled frame-buffer read address and delays the pixel-valid flag and coordinates to line up with BRAM read data.

## Interface
- FB_WIDTH, 240: frame-buffer columns.
- FB_HEIGHT, 320: frame-buffer rows.
- BRAM_LATENCY, 2: frame-buffer read latency in cycles (range 1..4).
- clk_in  input  1  pixel clock; one clock domain.
- rst_n_in  input  1  reset; asynchronous, active-low.
- btn_in  input  1  debounced scale-cycle button, level.
- new_frame_in  input  1  single-cycle pulse coincident with hcount_in=0, vcount_in=0.
- hcount_in  input  11  display column.
- vcount_in  input  10  display row.
- scale_out  output  2  scale currently applied.
- change_pending_out  output  1  high while the staged scale differs from scale_out.
- addr_out  output  17  frame-buffer read address.
- addr_valid_out  output  1  addr_out lies inside the frame buffer.
- pixel_valid_out  output  1  addr_valid_out delayed to align with BRAM data.
- hcount_out  output  11  hcount_in aligned with pixel_valid_out.
- vcount_out  output  10  vcount_in aligned with pixel_valid_out.

## Operation
- **Scale codes (decimation applied to hcount and vcount):**
  - 00: 1x, h/1, v/1.
  - 01: reserved; behaves as 00.
  - 10: wide, h/4, v/2.
  - 11: 2x, h/2, v/2.
- **Cycle order for button presses:** 00 -> 11 -> 10 -> 00. Code 01 steps to 11. Code 01 is never produced by the button.
- **Rising-edge detect on btn_in.** Each edge advances the staged register: `staged <= next(staged)`. Holding the button produces exactly one advance.
- **On new_frame_in:** `scale_out <= staged`. Presses between frame boundaries accumulate.
- **Press in the same cycle as new_frame_in:**
  - The staged value advances first.
  - scale_out takes the advanced value.
- **change_pending_out** is the registered compare `staged != scale_out`.
- **Stage 0 (registered):**
  - sh = hcount_in >> shift_h, sv = vcount_in >> shift_v, using the current scale_out.
  - valid0 = (sh < FB_WIDTH) && (sv < FB_HEIGHT).
  - Shifts are logical; widths are preserved.
- **Stage 1 (registered):**
  - addr_out = sh + FB_WIDTH*sv, computed as (sv<<8) - (sv<<4) + sh for the default 240. No DSP is required.
  - addr_valid_out = valid0.
  - When valid0 = 0, addr_out is forced to 0.
- **Alignment pipeline:** pixel_valid_out, hcount_out and vcount_out are a shift register of depth 2 + BRAM_LATENCY fed from valid0's source inputs.
- **Maximum address:** 76799 (sh=239, sv=319). It fits in 17 bits, so no wrap is possible.
- **Out-of-range inputs:** any hcount_in/vcount_in value, including blanking, gives addr_valid_out = 0. It is never an error.

## Timing
- **Reset values (all asynchronous on rst_n_in low):**
  - scale_out=00, staged=00, change_pending_out=0.
  - addr_out=0, addr_valid_out=0.
  - All alignment stages 0, so pixel_valid_out=0, hcount_out=0, vcount_out=0.
  - Edge-detect history register = 0, so a button held through reset release registers one press.
- **Reset release:** synchronous to clk_in at the design level. The first valid output appears 2 cycles after the first sampled input.
- **Latency:**
  - hcount_in/vcount_in -> addr_out/addr_valid_out: 2 cycles.
  - hcount_in/vcount_in -> pixel_valid_out/hcount_out/vcount_out: 2 + BRAM_LATENCY cycles.
- **Scale update timing:**
  - scale_out changes the cycle after new_frame_in.
  - The pixel sampled with new_frame_in (0,0) uses the old scale. It maps to address 0 and is valid under every scale, so the image is unaffected.
- **btn_in edge:** staged advances one cycle after the edge is sampled. change_pending_out follows one cycle later.
- **Throughput:** one address per cycle, no stalls, no back-pressure.
- **Reset mid-frame:** the pipeline flushes to invalid. Scale returns to 00 immediately, without waiting for a frame boundary.

## Test plan
- **Scale 00, h=100, v=50:** addr_out=12100, addr_valid_out=1 after 2 cycles. pixel_valid_out=1 with hcount_out=100 after 4 cycles (BRAM_LATENCY=2).
- **Scale 11, h=300, v=100:** addr_out=12150. h=480, v=0 -> addr_valid_out=0, addr_out=0.
- **Scale 10, h=959, v=639:** addr_out=76799, valid. h=960, v=639 -> invalid, addr_out=0.
- **Two btn_in pulses mid-frame from reset:**
  - scale_out stays 00 and change_pending_out=1.
  - After new_frame_in, scale_out=10 and change_pending_out=0.
  - btn held high for 100 cycles advances staged exactly once.
- **btn_in rising edge in the same cycle as new_frame_in, scale 00:** scale_out=11 the next cycle; change_pending_out stays 0.
- **rst_n_in asserted asynchronously mid-line with scale 11 and valid traffic:** all outputs go 0 and scale_out=00 without a clock edge. After release, the stream resumes with 1x addresses.
